// File: rtl/cbfp_pkg.sv
// rtl/cbfp_pkg.sv - shared constants and types for the CBFP block-scale count generator
package cbfp_pkg;

    localparam int CNT_SIZE   = 5;
    localparam int DIN_SIZE   = 23;
    localparam int ARRAY_NUM  = 4;
    localparam int ARRAY_SIZE = 16;

    // Largest positive value representable in a signed count of width cw
    function automatic int sat_max(input int cw);
        return (2 ** (cw - 1)) - 1;
    endfunction

    localparam int SAT_MAX = (2 ** (CNT_SIZE - 1)) - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_e;

endpackage

// File: rtl/cbfp_cnt_gen_if.sv
// rtl/cbfp_cnt_gen_if.sv - beat input and block-output bundle of cbfp_cnt_gen
interface cbfp_cnt_gen_if
    import cbfp_pkg::*;
#(
    parameter int cnt_size   = CNT_SIZE,
    parameter int din_size   = DIN_SIZE,
    parameter int array_num  = ARRAY_NUM,
    parameter int array_size = ARRAY_SIZE
);

    logic                                  valid_in;
    logic [array_size-1:0][din_size-1:0]   din;
    logic                                  valid_out;
    logic [array_size-1:0][din_size-1:0]   dout;
    logic [array_num-1:0][cnt_size-1:0]    cal_cnt;
    logic                                  blk_first;

    modport slave (
        input  valid_in, din,
        output valid_out, dout, cal_cnt, blk_first
    );

    modport master (
        output valid_in, din,
        input  valid_out, dout, cal_cnt, blk_first
    );

endinterface

// File: rtl/cbfp_rsb_min.sv
// rtl/cbfp_rsb_min.sv - per-beat minimum redundant-sign-bit count, saturated to the count range
module cbfp_rsb_min
    import cbfp_pkg::*;
#(
    parameter int cnt_size   = CNT_SIZE,
    parameter int din_size   = DIN_SIZE,
    parameter int array_size = ARRAY_SIZE
) (
    input  logic [array_size-1:0][din_size-1:0] din_i,
    output logic [cnt_size-1:0]                 cnt_o
);

    localparam int SatMax = sat_max(cnt_size);

    // Run length of bits matching the sign bit, scanning down from just below it
    function automatic int rsb(input logic [din_size-1:0] s);
        int  n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = din_size - 2; i >= 0; i--) begin
            if (run && (s[i] == s[din_size-1])) begin
                n++;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    int rsb_w [array_size];

    for (genvar j = 0; j < array_size; j++) begin : g_rsb
        assign rsb_w[j] = rsb(din_i[j]);
    end

    int min_v;

    always_comb begin
        min_v = din_size - 1;
        for (int j = 0; j < array_size; j++) begin
            if (rsb_w[j] < min_v) begin
                min_v = rsb_w[j];
            end
        end
        if (min_v > SatMax) begin
            cnt_o = cnt_size'(SatMax);
        end else begin
            cnt_o = cnt_size'(min_v);
        end
    end

endmodule

// File: rtl/cbfp_cnt_gen.sv
// rtl/cbfp_cnt_gen.sv - groups beats into blocks, buffers them in ping-pong banks and
// replays each completed block together with its per-beat scale counts
module cbfp_cnt_gen
    import cbfp_pkg::*;
#(
    parameter int cnt_size   = CNT_SIZE,
    parameter int din_size   = DIN_SIZE,
    parameter int array_num  = ARRAY_NUM,
    parameter int array_size = ARRAY_SIZE
) (
    input  logic           clk,
    input  logic           rstn,
    cbfp_cnt_gen_if.slave  bus
);

    localparam int IW = $clog2(array_num);

    typedef logic [array_size-1:0][din_size-1:0] beat_t;
    typedef logic [array_num-1:0][cnt_size-1:0]  cnts_t;

    logic [cnt_size-1:0] beat_cnt;

    cbfp_rsb_min #(
        .cnt_size   (cnt_size),
        .din_size   (din_size),
        .array_size (array_size)
    ) u_rsb_min (
        .din_i (bus.din),
        .cnt_o (beat_cnt)
    );

    beat_t               bank_data_q [2][array_num];
    logic [cnt_size-1:0] bank_cnt_q  [2][array_num];

    logic          wr_bank_q;
    logic [IW-1:0] wr_idx_q;
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    rd_state_e     state_q;
    logic          rd_bank_q;
    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] rd_idx_nx;

    logic  valid_q;
    logic  blk_first_q;
    beat_t dout_q;
    cnts_t cal_cnt_q;

    logic  blk_done;
    logic  drain_last;
    logic  start;
    logic  start_bank;
    cnts_t start_cnts;

    assign blk_done  = bus.valid_in && (wr_idx_q == IW'(array_num - 1));
    assign rd_idx_nx = rd_idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            bank_data_q[wr_bank_q][wr_idx_q] <= bus.din;
            bank_cnt_q[wr_bank_q][wr_idx_q]  <= beat_cnt;
        end
    end

    // A block may start draining on the very edge its last beat lands, so that
    // beat's count is taken straight from the input path instead of the bank.
    always_comb begin
        drain_last = (state_q == DRAIN) && (rd_idx_q == IW'(array_num - 1));
        start_bank = (state_q == DRAIN) ? ~rd_bank_q : wr_bank_q;
        if (state_q == IDLE) begin
            start = blk_done;
        end else begin
            start = drain_last &&
                    (full_q[start_bank] || (blk_done && (wr_bank_q == start_bank)));
        end
        for (int k = 0; k < array_num; k++) begin
            if (bus.valid_in && (wr_bank_q == start_bank) && (wr_idx_q == IW'(k))) begin
                start_cnts[k] = beat_cnt;
            end else begin
                start_cnts[k] = bank_cnt_q[start_bank][k];
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (drain_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (blk_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            valid_q     <= 1'b0;
            blk_first_q <= 1'b0;
            dout_q      <= '0;
            cal_cnt_q   <= '0;
        end else begin
            full_q <= full_d;
            if (bus.valid_in) begin
                wr_idx_q <= blk_done ? '0 : wr_idx_q + 1'b1;
            end
            if (blk_done) begin
                wr_bank_q <= ~wr_bank_q;
            end

            if (start) begin
                state_q     <= DRAIN;
                rd_bank_q   <= start_bank;
                rd_idx_q    <= '0;
                valid_q     <= 1'b1;
                blk_first_q <= 1'b1;
                dout_q      <= bank_data_q[start_bank][0];
                cal_cnt_q   <= start_cnts;
            end else if ((state_q == DRAIN) && !drain_last) begin
                rd_idx_q    <= rd_idx_nx;
                blk_first_q <= 1'b0;
                dout_q      <= bank_data_q[rd_bank_q][rd_idx_nx];
            end else begin
                state_q     <= IDLE;
                rd_idx_q    <= '0;
                valid_q     <= 1'b0;
                blk_first_q <= 1'b0;
                dout_q      <= '0;
                cal_cnt_q   <= '0;
            end
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.blk_first = blk_first_q;
    assign bus.dout      = dout_q;
    assign bus.cal_cnt   = cal_cnt_q;

endmodule

// File: doc/cbfp_cnt_gen.md
CBFP_CNT_GEN -- requirements
Module: cbfp_cnt_gen

Interface
REQ-001 Parameter: cnt_size, 5, signed width of each block-scale count.
REQ-002 Parameter: din_size, 23, signed sample width (in and out).
REQ-003 Parameter: array_num, 4, beats per CBFP block and number of cal_cnt entries.
REQ-004 Parameter: array_size, 16, samples per beat.
REQ-005 Port: clk  input  1  sole clock; all state on rising edge.
REQ-006 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-007 Port: valid_in  input  1  din holds a beat this cycle.
REQ-008 Port: din  input  array_size x din_size signed  input beat.
REQ-009 Port: valid_out  output  1  dout/cal_cnt hold a beat this cycle.
REQ-010 Port: dout  output  array_size x din_size signed  delayed beat, unmodified.
REQ-011 Port: cal_cnt  output  array_num x cnt_size signed  per-beat redundant-sign-bit counts of the current output block.
REQ-012 Port: blk_first  output  1  high with valid_out on beat 0 of a block.

Function
REQ-013 Per sample: rsb = count of bits below the MSB equal to the MSB, scanned down from bit din_size-2, range 0..din_size-1.
REQ-014 Per beat: beat_cnt = minimum rsb over all array_size samples, saturated to 2**(cnt_size-1)-1 (15).
REQ-015 Accepted beats are grouped in arrival order into blocks of array_num; beat k of a block yields cal_cnt[k].
REQ-016 Storage: two ping-pong banks, each array_num beats plus array_num counts; write bank toggles on each completed block.
REQ-017 Write side: 2-bit beat index increments per accepted beat; wraps 3->0 on block completion; gaps in valid_in hold index.
REQ-018 Read FSM states IDLE, DRAIN; IDLE->DRAIN the cycle after a bank completes; DRAIN->IDLE after beat 3 unless the other bank is already complete, then DRAIN continues with it without a gap.
REQ-019 In DRAIN, one beat per cycle, beats 0..3 in order, valid_out high for exactly array_num consecutive cycles per block.
REQ-020 cal_cnt holds all four counts of the draining block, constant for its four output cycles.
REQ-021 Latency: with continuous valid_in, beat k input at cycle t appears on dout at cycle t+array_num; fill cannot overrun the draining bank.
REQ-022 dout, cal_cnt, blk_first registered; when valid_out is low, dout, cal_cnt, blk_first are driven to 0.
REQ-023 Partial blocks are never output; they wait for completion.
REQ-024 All-zero or all-ones beat -> count saturates to 15; any sample at most-negative or max-positive value -> count 0.

Reset
REQ-025 rstn low: valid_out, blk_first, dout, cal_cnt = 0; beat index 0; write bank 0; FSM IDLE; bank-complete flags cleared.
REQ-026 Reset mid-block or mid-drain discards all buffered beats; the first beat after release is beat 0 of a new block.
REQ-027 Bank data arrays need no reset; only control and output registers are reset.

Structure
REQ-028 Package cbfp_pkg holds the default parameter constants, the read-FSM state enum, and the saturation maximum constant.
REQ-029 Sub-module cbfp_rsb_min: combinational per-beat count (REQ-013/014), array_size rsb units plus min tree; instantiated once on the input path.

Verification
REQ-030 Four continuous beats, all samples 0x000800 -> 4 cycles after beat 0, valid_out 4 cycles, cal_cnt = {10,10,10,10}, dout equals input, blk_first on first.
REQ-031 Beats with max magnitude 2**21, 2**15, 1, 0 -> cal_cnt = {0,6,15,15}.
REQ-032 Sample -4194304 in beat 2, others small -> cal_cnt[2] = 0.
REQ-033 12 continuous beats -> 12 consecutive valid_out cycles, no gap, cal_cnt changes only at blk_first.
REQ-034 Beats with valid_in gaps (1 on, 2 off) -> block output starts cycle after 4th accepted beat; outputs unchanged.
REQ-035 rstn asserted after 2 beats of a block -> no output; next 4 beats form a fresh block, output correct.
